// File: rtl/mcs4_timing_pkg.sv
// Shared constants for the MCS-4 timing board: subcycle indices, default phase
// widths and the hold handshake state type.
package mcs4_timing_pkg;

    localparam int SUBCYCLES = 8;

    localparam int A1 = 0;
    localparam int A2 = 1;
    localparam int A3 = 2;
    localparam int M1 = 3;
    localparam int M2 = 4;
    localparam int X1 = 5;
    localparam int X2 = 6;
    localparam int X3 = 7;

    // Default widths give a 68-sysclk subcycle, about 735 kHz from 50 MHz.
    localparam int DEF_CLK1_W = 19;
    localparam int DEF_GAP1_W = 15;
    localparam int DEF_CLK2_W = 19;
    localparam int DEF_GAP2_W = 15;

    typedef logic [SUBCYCLES-1:0] subcycle_t;

    typedef enum logic {
        RUNNING = 1'b0,
        HOLDING = 1'b1
    } hold_state_e;

    function automatic subcycle_t rotate_subcycle(input subcycle_t s);
        return {s[SUBCYCLES-2:0], s[SUBCYCLES-1]};
    endfunction

endpackage

// File: rtl/timing_sequencer_phase_gen.sv
// Subcycle phase counter: produces registered clk1/clk2, their next-edge values
// for the parent's decode, and the end-of-subcycle indication.
module phase_gen
    import mcs4_timing_pkg::*;
#(
    parameter int CLK1_W = DEF_CLK1_W,
    parameter int GAP1_W = DEF_GAP1_W,
    parameter int CLK2_W = DEF_CLK2_W,
    parameter int GAP2_W = DEF_GAP2_W
) (
    input  logic sysclk,
    input  logic poc,
    input  logic freeze,
    output logic clk1_nxt,
    output logic clk2_nxt,
    output logic clk1,
    output logic clk2,
    output logic end_of_subcycle
);

    localparam int P  = CLK1_W + GAP1_W + CLK2_W + GAP2_W;
    localparam int CW = $clog2(P);

    localparam logic [CW-1:0] LAST     = CW'(P - 1);
    localparam logic [CW-1:0] CLK1_END = CW'(CLK1_W);
    localparam logic [CW-1:0] CLK2_BEG = CW'(CLK1_W + GAP1_W);
    localparam logic [CW-1:0] CLK2_END = CW'(CLK1_W + GAP1_W + CLK2_W);

    if (CLK1_W < 1 || GAP1_W < 1 || CLK2_W < 1 || GAP2_W < 1) begin : g_bad_widths
        $error("phase_gen: every phase width must be at least 1");
    end

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Inactive means reset or hold: the first active edge starts at count 0
    // with clk1 already high, so no latency is added after release.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        active_d = active_q;
        cnt_d    = cnt_q;
        if (freeze) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (!active_q) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign clk1_nxt        = active_d && (cnt_d < CLK1_END);
    assign clk2_nxt        = active_d && (cnt_d >= CLK2_BEG) && (cnt_d < CLK2_END);
    assign end_of_subcycle = active_q && (cnt_q == LAST);

    always_ff @(posedge sysclk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (poc) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            clk1     <= 1'b0;
            clk2     <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            clk1     <= clk1_nxt;
            clk2     <= clk2_nxt;
        end
    end

endmodule

// File: rtl/timing_sequencer.sv
// MCS-4 timing sequencer: two-phase clocks, the A1..X3 one-hot subcycle ring,
// registered phase strobes, sync, and the X3-boundary hold handshake.
module timing_sequencer
    import mcs4_timing_pkg::*;
#(
    parameter int CLK1_W = DEF_CLK1_W,
    parameter int GAP1_W = DEF_GAP1_W,
    parameter int CLK2_W = DEF_CLK2_W,
    parameter int GAP2_W = DEF_GAP2_W
) (
    input  logic       sysclk,
    input  logic       poc,
    input  logic       hold_req,
    output logic       hold_ack,
    output logic       clk1,
    output logic       clk2,
    output logic [7:0] state,
    output logic       a12,
    output logic       a22,
    output logic       a32,
    output logic       m12,
    output logic       m22,
    output logic       x12,
    output logic       x22,
    output logic       x32,
    output logic       m11,
    output logic       x11,
    output logic       x21,
    output logic       x31,
    output logic       m12_m22_clk1_m11_m12,
    output logic       sync
);

    localparam subcycle_t RING_RESET = SUBCYCLES'(1);

    logic        clk1_nxt;
    logic        clk2_nxt;
    logic        end_of_subcycle;
    logic        freeze;
    subcycle_t   state_q, state_d;
    hold_state_e hold_q, hold_d;
    logic        m11_d, m12_d, m22_d, comp_d;

    phase_gen #(
        .CLK1_W(CLK1_W),
        .GAP1_W(GAP1_W),
        .CLK2_W(CLK2_W),
        .GAP2_W(GAP2_W)
    ) u_phase_gen (
        .sysclk         (sysclk),
        .poc            (poc),
        .freeze         (freeze),
        .clk1_nxt       (clk1_nxt),
        .clk2_nxt       (clk2_nxt),
        .clk1           (clk1),
        .clk2           (clk2),
        .end_of_subcycle(end_of_subcycle)
    );

    // The ring rotates on every wrap; entering hold from X3 therefore lands in A1.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        freeze  = 1'b0;
        if (end_of_subcycle) begin
            state_d = rotate_subcycle(state_q);
        end
        case (hold_q)
            RUNNING: begin
                if (end_of_subcycle && state_q[X3] && hold_req) begin
                    hold_d = HOLDING;
                    freeze = 1'b1;
                end
            end
            HOLDING: begin
                if (hold_req) begin
                    freeze = 1'b1;
                end else begin
                    hold_d = RUNNING;
                end
            end
        endcase
    end

    assign m11_d  = state_d[M1] & clk1_nxt;
    assign m12_d  = state_d[M1] & clk2_nxt;
    assign m22_d  = state_d[M2] & clk2_nxt;
    assign comp_d = m12_d | m22_d | (clk1_nxt & ~(m11_d | m12_d));

    always_ff @(posedge sysclk) begin
        if (poc) begin
            state_q              <= RING_RESET;
            hold_q               <= RUNNING;
            a12                  <= 1'b0;
            a22                  <= 1'b0;
            a32                  <= 1'b0;
            m12                  <= 1'b0;
            m22                  <= 1'b0;
            x12                  <= 1'b0;
            x22                  <= 1'b0;
            x32                  <= 1'b0;
            m11                  <= 1'b0;
            x11                  <= 1'b0;
            x21                  <= 1'b0;
            x31                  <= 1'b0;
            m12_m22_clk1_m11_m12 <= 1'b0;
            sync                 <= 1'b0;
        end else begin
            state_q              <= state_d;
            hold_q               <= hold_d;
            a12                  <= state_d[A1] & clk2_nxt;
            a22                  <= state_d[A2] & clk2_nxt;
            a32                  <= state_d[A3] & clk2_nxt;
            m12                  <= m12_d;
            m22                  <= m22_d;
            x12                  <= state_d[X1] & clk2_nxt;
            x22                  <= state_d[X2] & clk2_nxt;
            x32                  <= state_d[X3] & clk2_nxt;
            m11                  <= m11_d;
            x11                  <= state_d[X1] & clk1_nxt;
            x21                  <= state_d[X2] & clk1_nxt;
            x31                  <= state_d[X3] & clk1_nxt;
            m12_m22_clk1_m11_m12 <= comp_d;
            sync                 <= state_d[X3];
        end
    end

    assign state    = state_q;
    assign hold_ack = (hold_q == HOLDING);

endmodule
